// File: rtl/mipi_csi_rx_packet_decoder_8b2lane.sv
// CSI-2 packet decoder for a 2-lane, lane-aligned byte stream.
// It checks the header ECC, forwards long-packet payload beats and turns short packets into frame/line strobes.
module mipi_csi_rx_packet_decoder_8b2lane #(
  parameter int ECC_CHECK = 1
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        data_valid_i,
  input  logic [15:0] data_i,
  output logic        output_valid_o,
  output logic [15:0] output_o,
  output logic [2:0]  packet_type_o,
  output logic        frame_start_o,
  output logic        frame_end_o,
  output logic        line_start_o,
  output logic        line_end_o,
  output logic        ecc_error_o,
  output logic        truncated_o
);

  typedef enum logic [1:0] {IDLE, HDR1, PAYLOAD, DRAIN} state_t;

  state_t      state;
  logic [7:0]  di_q;
  logic [7:0]  wc_l_q;
  logic [15:0] remaining;
  logic        emit_q;

  logic [15:0] wc;
  logic [7:0]  ecc_calc;
  logic        ecc_bad;

  // CSI-2 6-bit Hamming parity over {WC_H, WC_L, DI}. Bits [7:6] are always zero.
  function automatic logic [7:0] csi_ecc(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
    p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
    p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
    p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
    p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
    p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
    return {2'b00, p};
  endfunction

  function automatic logic [2:0] decode_type(input logic [5:0] dt);
    case (dt)
      6'h2A:   return 3'd1;
      6'h2B:   return 3'd2;
      6'h2C:   return 3'd4;
      6'h2D:   return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

  // NOTE: every signal written in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    wc       = {data_i[7:0], wc_l_q};
    ecc_calc = csi_ecc({wc, di_q});
    ecc_bad  = (ECC_CHECK != 0) && (data_i[15:8] != ecc_calc);
  end

  // NOTE: sequential state uses non-blocking assignments, so every branch reads the pre-edge values.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state          <= IDLE;
      di_q           <= '0;
      wc_l_q         <= '0;
      remaining      <= '0;
      emit_q         <= 1'b0;
      output_valid_o <= 1'b0;
      output_o       <= '0;
      packet_type_o  <= '0;
      frame_start_o  <= 1'b0;
      frame_end_o    <= 1'b0;
      line_start_o   <= 1'b0;
      line_end_o     <= 1'b0;
      ecc_error_o    <= 1'b0;
      truncated_o    <= 1'b0;
    end else begin
      output_valid_o <= 1'b0;
      output_o       <= '0;
      frame_start_o  <= 1'b0;
      frame_end_o    <= 1'b0;
      line_start_o   <= 1'b0;
      line_end_o     <= 1'b0;
      ecc_error_o    <= 1'b0;
      truncated_o    <= 1'b0;

      case (state)
        IDLE: begin
          if (data_valid_i) begin
            di_q   <= data_i[7:0];
            wc_l_q <= data_i[15:8];
            state  <= HDR1;
          end
        end

        HDR1: begin
          if (!data_valid_i) begin
            truncated_o <= 1'b1;
            state       <= IDLE;
          end else if (ecc_bad) begin
            ecc_error_o <= 1'b1;
            state       <= DRAIN;
          end else if (di_q[5:0] <= 6'h0F) begin
            // The virtual channel in DI[7:6] is ignored. DT 0x04..0x0F are generic short packets with no strobe.
            frame_start_o <= (di_q[5:0] == 6'h00);
            frame_end_o   <= (di_q[5:0] == 6'h01);
            line_start_o  <= (di_q[5:0] == 6'h02);
            line_end_o    <= (di_q[5:0] == 6'h03);
            state         <= DRAIN;
          end else begin
            remaining     <= wc;
            packet_type_o <= decode_type(di_q[5:0]);
            emit_q        <= (decode_type(di_q[5:0]) != 3'd0);
            state         <= (wc == 16'd0) ? DRAIN : PAYLOAD;
          end
        end

        PAYLOAD: begin
          if (!data_valid_i) begin
            truncated_o <= 1'b1;
            state       <= IDLE;
          end else begin
            output_valid_o <= emit_q;
            if (emit_q)
              output_o <= (remaining == 16'd1) ? {8'h00, data_i[7:0]} : data_i;
            if (remaining <= 16'd2) begin
              remaining <= '0;
              state     <= DRAIN;
            end else begin
              remaining <= remaining - 16'd2;
            end
          end
        end

        DRAIN: begin
          if (!data_valid_i)
            state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mipi_csi_rx_packet_decoder_8b2lane.sv
// Directed bench for the CSI-2 packet decoder. It applies a cycle-by-cycle vector table, then runs
// hand-written sequences for reset during payload and for a second instance built with ECC checking disabled.
module tb_mipi_csi_rx_packet_decoder_8b2lane;

  localparam logic [5:0] P_FS  = 6'b100000;
  localparam logic [5:0] P_FE  = 6'b010000;
  localparam logic [5:0] P_LS  = 6'b001000;
  localparam logic [5:0] P_LE  = 6'b000100;
  localparam logic [5:0] P_ECC = 6'b000010;
  localparam logic [5:0] P_TR  = 6'b000001;

  // Syndrome code of each header bit, listed from D23 down to D0.
  localparam logic [143:0] ECC_CODES = {
    6'h3B, 6'h37, 6'h2F, 6'h1F, 6'h38, 6'h34, 6'h32, 6'h31,
    6'h2C, 6'h2A, 6'h29, 6'h26, 6'h25, 6'h23, 6'h1C, 6'h1A,
    6'h19, 6'h16, 6'h15, 6'h13, 6'h0E, 6'h0D, 6'h0B, 6'h07};

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        ov;
    logic [15:0] od;
    logic [2:0]  pt;
    logic [5:0]  pl;
  } vec_t;

  logic        clk;
  logic        reset_n;
  logic        data_valid;
  logic [15:0] data;

  logic        ov0, fs0, fe0, ls0, le0, ecc0, tr0;
  logic [15:0] od0;
  logic [2:0]  pt0;
  logic        ov1, fs1, fe1, ls1, le1, ecc1, tr1;
  logic [15:0] od1;
  logic [2:0]  pt1;
  logic [5:0]  pulses0, pulses1;

  int   checks   = 0;
  int   failures = 0;
  vec_t vecs[$];

  assign pulses0 = {fs0, fe0, ls0, le0, ecc0, tr0};
  assign pulses1 = {fs1, fe1, ls1, le1, ecc1, tr1};

  mipi_csi_rx_packet_decoder_8b2lane #(.ECC_CHECK(1)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .data_valid_i(data_valid), .data_i(data),
    .output_valid_o(ov0), .output_o(od0), .packet_type_o(pt0),
    .frame_start_o(fs0), .frame_end_o(fe0), .line_start_o(ls0), .line_end_o(le0),
    .ecc_error_o(ecc0), .truncated_o(tr0));

  mipi_csi_rx_packet_decoder_8b2lane #(.ECC_CHECK(0)) dut_noecc (
    .clk_i(clk), .reset_n_i(reset_n), .data_valid_i(data_valid), .data_i(data),
    .output_valid_o(ov1), .output_o(od1), .packet_type_o(pt1),
    .frame_start_o(fs1), .frame_end_o(fe1), .line_start_o(ls1), .line_end_o(le1),
    .ecc_error_o(ecc1), .truncated_o(tr1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ref_ecc(input logic [7:0] di, input logic [15:0] wc);
    logic [23:0]  d;
    logic [143:0] codes;
    logic [5:0]   syn;
    d     = {wc, di};
    codes = ECC_CODES;
    syn   = '0;
    for (int i = 0; i < 24; i++)
      if (d[i]) syn ^= codes[i*6 +: 6];
    return {2'b00, syn};
  endfunction

  function automatic logic [15:0] hdr0(input logic [7:0] di, input logic [15:0] wc);
    return {wc[7:0], di};
  endfunction

  function automatic logic [15:0] hdr1(input logic [7:0] di, input logic [15:0] wc, input logic [7:0] flip);
    return {ref_ecc(di, wc) ^ flip, wc[15:8]};
  endfunction

  task automatic add(input logic v, input logic [15:0] d, input logic ov, input logic [15:0] od,
                     input logic [2:0] pt, input logic [5:0] pl);
    vec_t r;
    r.v = v; r.d = d; r.ov = ov; r.od = od; r.pt = pt; r.pl = pl;
    vecs.push_back(r);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [15:0] d);
    @(negedge clk);
    data_valid = v;
    data       = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n    = 1'b0;
    data_valid = 1'b0;
    data       = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset valid", ov0, 0);
    check("reset data", od0, 0);
    check("reset type", pt0, 0);
    check("reset pulses", pulses0, 0);
    @(negedge clk);
    reset_n = 1'b1;

    add(0, 16'h0000, 0, 16'h0000, 0, 0);
    // RAW12, WC=6, 2-byte CRC
    add(1, hdr0(8'h2C, 6), 0, 0, 0, 0);
    add(1, hdr1(8'h2C, 6, 0), 0, 0, 4, 0);
    add(1, 16'h0201, 1, 16'h0201, 4, 0);
    add(1, 16'h0403, 1, 16'h0403, 4, 0);
    add(1, 16'h0605, 1, 16'h0605, 4, 0);
    add(1, 16'hBEEF, 0, 0, 4, 0);
    add(0, 16'h0000, 0, 0, 4, 0);
    // RAW8, odd WC=3: the upper byte of the last beat is forced to zero
    add(1, hdr0(8'h2A, 3), 0, 0, 4, 0);
    add(1, hdr1(8'h2A, 3, 0), 0, 0, 1, 0);
    add(1, 16'hBBAA, 1, 16'hBBAA, 1, 0);
    add(1, 16'h11CC, 1, 16'h00CC, 1, 0);
    add(1, 16'h2233, 0, 0, 1, 0);
    add(0, 16'h0000, 0, 0, 1, 0);
    // Short packets FS, FE, LS on VC1, LE, generic 0x0F
    add(1, hdr0(8'h00, 1), 0, 0, 1, 0);
    add(1, hdr1(8'h00, 1, 0), 0, 0, 1, P_FS);
    add(0, 16'h0000, 0, 0, 1, 0);
    add(1, hdr0(8'h01, 1), 0, 0, 1, 0);
    add(1, hdr1(8'h01, 1, 0), 0, 0, 1, P_FE);
    add(0, 16'h0000, 0, 0, 1, 0);
    add(1, hdr0(8'h42, 5), 0, 0, 1, 0);
    add(1, hdr1(8'h42, 5, 0), 0, 0, 1, P_LS);
    add(0, 16'h0000, 0, 0, 1, 0);
    add(1, hdr0(8'h03, 5), 0, 0, 1, 0);
    add(1, hdr1(8'h03, 5, 0), 0, 0, 1, P_LE);
    add(0, 16'h0000, 0, 0, 1, 0);
    add(1, hdr0(8'h0F, 0), 0, 0, 1, 0);
    add(1, hdr1(8'h0F, 0, 0), 0, 0, 1, 0);
    add(0, 16'h0000, 0, 0, 1, 0);
    // DT 0x10 is the first long type; it is unsupported, so the payload is consumed silently
    add(1, hdr0(8'h10, 2), 0, 0, 1, 0);
    add(1, hdr1(8'h10, 2, 0), 0, 0, 0, 0);
    add(1, 16'hAAAA, 0, 0, 0, 0);
    add(0, 16'h0000, 0, 0, 0, 0);
    // ECC error, then a good packet
    add(1, hdr0(8'h2C, 4), 0, 0, 0, 0);
    add(1, hdr1(8'h2C, 4, 8'h04), 0, 0, 0, P_ECC);
    add(1, 16'h2211, 0, 0, 0, 0);
    add(1, 16'h4433, 0, 0, 0, 0);
    add(1, 16'h5555, 0, 0, 0, 0);
    add(0, 16'h0000, 0, 0, 0, 0);
    add(1, hdr0(8'h2D, 2), 0, 0, 0, 0);
    add(1, hdr1(8'h2D, 2, 0), 0, 0, 5, 0);
    add(1, 16'h7766, 1, 16'h7766, 5, 0);
    add(1, 16'h9988, 0, 0, 5, 0);
    add(0, 16'h0000, 0, 0, 5, 0);
    // Long packet with WC=0
    add(1, hdr0(8'h2B, 0), 0, 0, 5, 0);
    add(1, hdr1(8'h2B, 0, 0), 0, 0, 2, 0);
    add(1, 16'h1234, 0, 0, 2, 0);
    add(0, 16'h0000, 0, 0, 2, 0);
    // Truncation after 2 beats of WC=8
    add(1, hdr0(8'h2B, 8), 0, 0, 2, 0);
    add(1, hdr1(8'h2B, 8, 0), 0, 0, 2, 0);
    add(1, 16'h0201, 1, 16'h0201, 2, 0);
    add(1, 16'h0403, 1, 16'h0403, 2, 0);
    add(0, 16'h0000, 0, 0, 2, P_TR);
    add(0, 16'h0000, 0, 0, 2, 0);
    // Truncation inside the header
    add(1, hdr0(8'h2A, 2), 0, 0, 2, 0);
    add(0, 16'h0000, 0, 0, 2, P_TR);
    add(0, 16'h0000, 0, 0, 2, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].v, vecs[i].d);
      check($sformatf("row%0d valid", i), ov0, vecs[i].ov);
      check($sformatf("row%0d data", i), od0, vecs[i].od);
      check($sformatf("row%0d type", i), pt0, vecs[i].pt);
      check($sformatf("row%0d pulses", i), pulses0, vecs[i].pl);
    end

    // Reset in the middle of the payload
    step(1, hdr0(8'h2C, 6));
    step(1, hdr1(8'h2C, 6, 0));
    check("mid type", pt0, 4);
    step(1, 16'h0201);
    check("mid beat", od0, 16'h0201);
    #2 reset_n = 1'b0;
    #1;
    check("async valid", ov0, 0);
    check("async data", od0, 0);
    check("async type", pt0, 0);
    check("async pulses", pulses0, 0);
    @(negedge clk);
    data_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    step(0, 16'h0000);
    check("post reset idle", {ov0, pulses0}, 0);
    step(1, hdr0(8'h2D, 4));
    step(1, hdr1(8'h2D, 4, 0));
    check("fresh type", pt0, 5);
    step(1, 16'h0A09);
    check("fresh beat0", {ov0, od0}, {1'b1, 16'h0A09});
    step(1, 16'h0C0B);
    check("fresh beat1", {ov0, od0}, {1'b1, 16'h0C0B});
    step(1, 16'hFFFF);
    check("fresh crc", ov0, 0);
    step(0, 16'h0000);

    // Bad ECC: the checking instance rejects it, the non-checking instance forwards it
    step(1, hdr0(8'h2C, 4));
    step(1, hdr1(8'h2C, 4, 8'h01));
    check("chk ecc pulse", ecc0, 1);
    check("chk type held", pt0, 5);
    check("nochk ecc pulse", ecc1, 0);
    check("nochk type", pt1, 4);
    step(1, 16'h2211);
    check("chk no beat", ov0, 0);
    check("nochk beat0", {ov1, od1}, {1'b1, 16'h2211});
    step(1, 16'h4433);
    check("nochk beat1", {ov1, od1}, {1'b1, 16'h4433});
    step(1, 16'h6655);
    check("nochk crc", ov1, 0);
    step(0, 16'h0000);
    check("chk ecc once", ecc0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
